// File: rtl/fp_result_wb_pkg.sv
// Shared FP special-characters package: fflags bit positions and canonical quiet NaN.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package fp_result_wb_pkg;

    // Positions of the sticky exception bits inside fflags {NV,DZ,OF,UF,NX}.
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // Canonical single-precision quiet NaN.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // True for any single-precision NaN: exponent all ones, mantissa nonzero.
    function automatic logic is_nan32(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Result/tag storage for the FP writeback stage: circular buffer with occupancy count.
// Latency: pushed entry is on dout the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, rst (async active-low), push/din, pop, dout (zero when empty),
//        full, empty, count (0..DEPTH).
module fp_wb_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop frees the slot in the same cycle, so a push into a full buffer
    // is legal whenever the head is leaving.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head is forced to zero when empty so idle outputs are deterministic.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_result_wb.sv
// FP result writeback: edge-captures unit results into a small FIFO, accumulates sticky fflags.
// Latency: 1 cycle from capture (done rising) to wb_valid; fflags update 1 cycle after capture.
// Backpressure: wb_ready=0 holds the head stable; a capture into a full FIFO without pop is dropped and sets overrun.
//
// Ports: clk, rst (async active-low); res_in/tag_in/ov/un/inv/inexact/dz/done from the FP unit;
//        wb_valid/wb_ready/wb_data/wb_tag writeback handshake; fflags (sticky {NV,DZ,OF,UF,NX}),
//        flag_clr (sync clear of fflags and overrun), overrun (sticky drop flag), in_ready (FIFO not full).
// Build option: define FP_WB_NAN_CANON_EN to replace captured NaNs with the canonical quiet NaN
//        (assumes W >= 32, single-precision layout in res_in[31:0]).
module fp_result_wb
    import fp_result_wb_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int TW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  res_in,
    input  logic [TW-1:0] tag_in,
    input  logic          ov,
    input  logic          un,
    input  logic          inv,
    input  logic          inexact,
    input  logic          dz,
    input  logic          done,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [W-1:0]  wb_data,
    output logic [TW-1:0] wb_tag,
    output logic [4:0]    fflags,
    input  logic          flag_clr,
    output logic          overrun,
    output logic          in_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          done_q;
    logic          arm_q;
    logic          capture;
    logic          pop;
    logic          accept;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [W-1:0]  push_res;
    logic [4:0]    new_flags;

    // arm_q stays low for the first edge after reset release, so a done that
    // was already high during reset is never mistaken for a fresh result.
    assign capture = done & ~done_q & arm_q;
    assign pop     = wb_valid & wb_ready;
    assign accept  = capture & (~fifo_full | pop);
    assign drop    = capture & fifo_full & ~pop;

    assign wb_valid = ~fifo_empty;
    assign in_ready = (fifo_count < DEPTH_C);

    always_comb begin
        push_res = res_in;
`ifdef FP_WB_NAN_CANON_EN
        if (is_nan32(res_in[31:0])) push_res = W'(FP_QNAN);
`endif
    end

    always_comb begin
        new_flags        = '0;
        new_flags[FF_NV] = inv;
        new_flags[FF_DZ] = dz;
        new_flags[FF_OF] = ov;
        new_flags[FF_UF] = un;
        new_flags[FF_NX] = inexact;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
            fflags  <= '0;
            overrun <= 1'b0;
        end else begin
            done_q <= done;
            arm_q  <= 1'b1;
            // Clear wins over a same-cycle accumulate; that capture's flags are lost.
            if (flag_clr) begin
                fflags  <= '0;
                overrun <= 1'b0;
            end else begin
                if (accept) fflags  <= fflags | new_flags;
                if (drop)   overrun <= 1'b1;
            end
        end
    end

    fp_wb_fifo #(
        .DW    (W + TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   ({tag_in, push_res}),
        .pop   (pop),
        .dout  ({wb_tag, wb_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fp_result_wb.sv
// Bench for fp_result_wb: queue-based behavioural model compared every negedge,
// plus directed scenarios with literal expectations.
// Build option FP_WB_NAN_CANON_EN selects the expected NaN handling.
module tb_fp_result_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] res_in;
    logic [4:0]  tag_in;
    logic        ov, un, inv, inexact, dz;
    logic        done;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic [4:0]  fflags;
    logic        flag_clr;
    logic        overrun;
    logic        in_ready;

    always #5 clk = ~clk;

    fp_result_wb #(.W(32), .DEPTH(2), .TW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .res_in   (res_in),
        .tag_in   (tag_in),
        .ov       (ov),
        .un       (un),
        .inv      (inv),
        .inexact  (inexact),
        .dz       (dz),
        .done     (done),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_tag   (wb_tag),
        .fflags   (fflags),
        .flag_clr (flag_clr),
        .overrun  (overrun),
        .in_ready (in_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } ent_t;

`ifdef FP_WB_NAN_CANON_EN
    localparam logic [31:0] EXP_NAN = 32'h7FC0_0000;
`else
    localparam logic [31:0] EXP_NAN = 32'h7F80_0001;
`endif

    // ---------------- behavioural model ----------------
    ent_t       m_q[$];
    logic [4:0] m_flags = '0;
    logic       m_ovr   = 1'b0;
    logic       m_prev  = 1'b0;
    logic       m_first = 1'b1;

    function automatic logic [31:0] canon(input logic [31:0] v);
`ifdef FP_WB_NAN_CANON_EN
        if (v[30:23] == 8'hFF && v[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
        return v;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_q.delete();
            m_flags = '0;
            m_ovr   = 1'b0;
            m_prev  = 1'b0;
            m_first = 1'b1;
        end else begin : model_step
            logic cap, mpop, mfull, acc;
            ent_t e;
            cap     = done && !m_prev && !m_first;
            m_prev  = done;
            m_first = 1'b0;
            mpop    = (m_q.size() != 0) && wb_ready;
            mfull   = (m_q.size() == 2);
            acc     = 1'b0;
            if (mpop) void'(m_q.pop_front());
            if (cap && (!mfull || mpop)) begin
                e.d = canon(res_in);
                e.t = tag_in;
                m_q.push_back(e);
                acc = 1'b1;
            end
            if (flag_clr) begin
                m_flags = '0;
                m_ovr   = 1'b0;
            end else begin
                if (acc)         m_flags = m_flags | {inv, dz, ov, un, inexact};
                if (cap && !acc) m_ovr = 1'b1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk);
        check("wb_valid", wb_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("wb_data", wb_data, m_q[0].d);
            check("wb_tag", wb_tag, m_q[0].t);
        end else if (!rst) begin
            check("wb_data_rst", wb_data, 0);
            check("wb_tag_rst", wb_tag, 0);
        end
        check("fflags", fflags, m_flags);
        check("overrun", overrun, m_ovr);
        check("in_ready", in_ready, m_q.size() < 2);
    end

    // Log of handshakes the DUT performs (recorded at negedge, completes at next posedge).
    ent_t dut_wb[$];
    initial forever begin
        @(negedge clk);
        if (rst && wb_valid && wb_ready) dut_wb.push_back({wb_data, wb_tag});
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One done pulse: f = {inv,dz,ov,un,inexact}.
    task automatic pulse(input logic [31:0] d, input logic [4:0] t, input logic [4:0] f);
        res_in = d;
        tag_in = t;
        {inv, dz, ov, un, inexact} = f;
        done = 1'b1;
        step(1);
        done = 1'b0;
        {inv, dz, ov, un, inexact} = 5'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b0; done = 1'b0; wb_ready = 1'b0; res_in = '0; tag_in = '0;
        ov = 1'b0; un = 1'b0; inv = 1'b0; inexact = 1'b0; dz = 1'b0; flag_clr = 1'b0;
        step(3);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fflags", fflags, 0);
        check("rst_overrun", overrun, 0);
        check("rst_wb_data", wb_data, 0);
        rst = 1'b1;
        step(2);

        // done held three cycles -> one writeback
        dut_wb.delete();
        wb_ready = 1'b1;
        res_in = 32'h4000_0000; tag_in = 5'd5; done = 1'b1;
        step(3);
        done = 1'b0;
        step(3);
        check("held_done_count", dut_wb.size(), 1);
        if (dut_wb.size() > 0) begin
            check("held_done_data", dut_wb[0].d, 32'h4000_0000);
            check("held_done_tag", dut_wb[0].t, 5);
        end
        check("held_done_fflags", fflags, 0);

        // flag accumulation and clear
        pulse(32'h3F80_0000, 5'd1, 5'b00001);
        pulse(32'h7FC0_0000, 5'd2, 5'b10000);
        step(1);
        check("fflags_accum", fflags, 5'b10001);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check("fflags_clear", fflags, 0);
        step(2);

        // overflow with wb_ready low
        dut_wb.delete();
        wb_ready = 1'b0;
        pulse(32'h1111_1111, 5'd1, 5'b0);
        pulse(32'h2222_2222, 5'd2, 5'b0);
        check("full_in_ready", in_ready, 0);
        pulse(32'h3333_3333, 5'd3, 5'b0);
        check("drop_overrun", overrun, 1);
        wb_ready = 1'b1;
        step(3);
        wb_ready = 1'b0;
        check("drain_count", dut_wb.size(), 2);
        if (dut_wb.size() == 2) begin
            check("drain0_data", dut_wb[0].d, 32'h1111_1111);
            check("drain0_tag", dut_wb[0].t, 1);
            check("drain1_data", dut_wb[1].d, 32'h2222_2222);
            check("drain1_tag", dut_wb[1].t, 2);
        end
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check("overrun_clear", overrun, 0);

        // full FIFO, capture and pop in the same cycle
        dut_wb.delete();
        pulse(32'h4444_4444, 5'd4, 5'b0);
        pulse(32'h5555_5555, 5'd6, 5'b0);
        res_in = 32'h6666_6666; tag_in = 5'd7; done = 1'b1; wb_ready = 1'b1;
        step(1);
        done = 1'b0; wb_ready = 1'b0;
        check("simul_in_ready", in_ready, 0);
        check("simul_overrun", overrun, 0);
        check("simul_head", wb_data, 32'h5555_5555);
        check("simul_head_tag", wb_tag, 6);
        wb_ready = 1'b1;
        step(3);
        wb_ready = 1'b0;
        check("simul_count", dut_wb.size(), 3);
        if (dut_wb.size() == 3) check("simul_last", dut_wb[2].d, 32'h6666_6666);

        // NaN handling
        pulse(32'h7F80_0001, 5'd8, 5'b0);
        check("nan_data", wb_data, EXP_NAN);
        wb_ready = 1'b1;
        step(2);
        wb_ready = 1'b0;

        // reset mid-operation with done high
        pulse(32'h7777_7777, 5'd9, 5'b0);
        pulse(32'h8888_8888, 5'd10, 5'b0);
        res_in = 32'h9999_9999; tag_in = 5'd11; done = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("midrst_wb_valid", wb_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(3);
        check("post_rst_no_capture", wb_valid, 0);
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("post_rst_capture", wb_valid, 1);
        check("post_rst_data", wb_data, 32'h9999_9999);
        wb_ready = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
